// File: rtl/divider_pkg.sv
// Shared CPU package: divider widths, FSM states and result-select opcodes.
package divider_pkg;

   localparam int DIV_WIDTH = 16;

   localparam logic [3:0] DIVQ = 4'b0101;
   localparam logic [3:0] DIVR = 4'b0110;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      ZERO,
      DONE
   } div_state_e;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division step: shift in a dividend bit, try subtracting the divisor.
import divider_pkg::*;

module div_step #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             quo_bit
);

   logic [WIDTH+1:0] trial;

   // Top bit of trial is the borrow of the trial subtraction
   assign trial   = {rem_in, dividend_bit} - {2'b00, divisor};
   assign quo_bit = ~trial[WIDTH+1];
   assign rem_out = quo_bit ? trial[WIDTH:0]
                            : {rem_in[WIDTH-1:0], dividend_bit};

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider; Q = {quotient, remainder}.
import divider_pkg::*;

module divider #(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] Q,
   output logic               QVALID,
   output logic               busy,
   output logic               div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_e         state, state_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [WIDTH-1:0]   a_q, a_n;
   logic [WIDTH-1:0]   b_q, b_n;
   logic [WIDTH:0]     rem_q, rem_n;
   logic [2*WIDTH-1:0] q_q, q_n;
   logic               qv_q, qv_n;
   logic               busy_q, busy_n;
   logic               dbz_q, dbz_n;

   logic [WIDTH:0]     step_rem;
   logic               step_bit;
   logic [WIDTH-1:0]   quo_next;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem_q),
      .dividend_bit (a_q[WIDTH-1]),
      .divisor      (b_q),
      .rem_out      (step_rem),
      .quo_bit      (step_bit)
   );

   // Dividend shifts out MSB-first while quotient bits fill from the LSB
   assign quo_next = {a_q[WIDTH-2:0], step_bit};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rem_q  <= '0;
         q_q    <= '0;
         qv_q   <= 1'b0;
         busy_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         a_q    <= a_n;
         b_q    <= b_n;
         rem_q  <= rem_n;
         q_q    <= q_n;
         qv_q   <= qv_n;
         busy_q <= busy_n;
         dbz_q  <= dbz_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      a_n     = a_q;
      b_n     = b_q;
      rem_n   = rem_q;
      q_n     = q_q;
      qv_n    = qv_q;
      busy_n  = busy_q;
      dbz_n   = dbz_q;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               a_n     = A;
               b_n     = B;
               rem_n   = '0;
               cnt_n   = '0;
               qv_n    = 1'b0;
               dbz_n   = 1'b0;
               busy_n  = 1'b1;
               state_n = (B == '0) ? ZERO : RUN;
            end
         end
         RUN: begin
            a_n   = quo_next;
            rem_n = step_rem;
            cnt_n = cnt + 1'b1;
            if (cnt == LAST) begin
               cnt_n   = '0;
               q_n     = {quo_next, step_rem[WIDTH-1:0]};
               qv_n    = 1'b1;
               busy_n  = 1'b0;
               state_n = DONE;
            end
         end
         ZERO: begin
            q_n     = {{WIDTH{1'b1}}, a_q};
            dbz_n   = 1'b1;
            qv_n    = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign Q           = q_q;
   assign QVALID      = qv_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results queued at issue, popped on QVALID.
module tb_divider;

   localparam int W = 16;

   typedef struct {
      logic [2*W-1:0] q;
      logic           dbz;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   A = '0;
   logic [W-1:0]   B = '0;
   logic [2*W-1:0] Q;
   logic           QVALID;
   logic           busy;
   logic           div_by_zero;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic qv_prev = 1'b0;

   divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .A           (A),
      .B           (B),
      .Q           (Q),
      .QVALID      (QVALID),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q   = {{W{1'b1}}, a};
         e.dbz = 1'b1;
      end else begin
         e.q   = {a / b, a % b};
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard monitor: every rising QVALID must match the oldest expectation
   always @(negedge clk) begin
      if (QVALID && !qv_prev) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_qvalid: Q=%h dbz=%b, no result pending", Q, div_by_zero);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (Q !== e.q || div_by_zero !== e.dbz) begin
               errors++;
               $display("FAIL result: Q=%h dbz=%b, expected Q=%h dbz=%b", Q, div_by_zero, e.q, e.dbz);
            end
         end
      end
      qv_prev = QVALID;
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      sb.push_back(model(a, b));
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (QVALID) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (Q !== '0) begin
         errors++;
         $display("FAIL reset_q: Q=%h, expected 0", Q);
      end
      checks++;
      if (QVALID !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: qv=%b busy=%b dbz=%b, expected 000", QVALID, busy, div_by_zero);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      issue(16'd100, 16'd7);
      checks++;
      if (busy !== 1'b1 || QVALID !== 1'b0) begin
         errors++;
         $display("FAIL basic_accept: busy=%b qv=%b, expected 1 0", busy, QVALID);
      end
      repeat (7) @(posedge clk);
      #1;
      checks++;
      if (Q !== 32'h0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_hold: Q=%h busy=%b, expected 0 1", Q, busy);
      end
      wait_valid(n);
      checks++;
      if (n + 7 !== 16) begin
         errors++;
         $display("FAIL basic_latency: %0d edges, expected 16", n + 7);
      end
      checks++;
      if (busy !== 1'b0 || Q !== 32'h000E_0002) begin
         errors++;
         $display("FAIL basic_done: busy=%b Q=%h, expected 0 000e0002", busy, Q);
      end
   endtask

   task automatic test_patterns();
      logic [W-1:0] ta[6];
      logic [W-1:0] tb[6];
      int n;
      ta = '{16'hFFFF, 16'd3, 16'd0, 16'hFFFF, 16'h1234, 16'd7};
      tb = '{16'd1, 16'd10, 16'd9, 16'hFFFF, 16'h0001, 16'd7};
      ta[4] = 16'($urandom_range(0, 65535));
      tb[4] = 16'($urandom_range(1, 65535));
      for (int i = 0; i < 6; i++) begin
         issue(ta[i], tb[i]);
         wait_valid(n);
         checks++;
         if (n !== 16) begin
            errors++;
            $display("FAIL pattern_latency[%0d]: %0d edges, expected 16", i, n);
         end
      end
   endtask

   task automatic test_zero();
      int n;
      logic [2*W-1:0] held;
      issue(16'd5, 16'd0);
      wait_valid(n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL zero_latency: %0d edges after accept, expected 1", n);
      end
      checks++;
      if (Q !== 32'hFFFF_0005 || div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL zero_result: Q=%h dbz=%b, expected ffff0005 1", Q, div_by_zero);
      end
      held = Q;
      A = 16'hAAAA;
      B = 16'h0003;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (Q !== held || QVALID !== 1'b1 || div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL done_hold: Q=%h qv=%b dbz=%b, expected %h 1 1", Q, QVALID, div_by_zero, held);
      end
   endtask

   task automatic test_ignore();
      int n;
      logic [2*W-1:0] prev;
      prev = Q;
      issue(16'd100, 16'd7);
      repeat (4) @(posedge clk);
      #1;
      A     = 16'd9;
      B     = 16'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = 16'h5555;
      B     = 16'd0;
      checks++;
      if (Q !== prev || busy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_hold: Q=%h busy=%b, expected %h 1", Q, busy, prev);
      end
      wait_valid(n);
      checks++;
      if (n + 5 !== 16 || Q !== 32'h000E_0002) begin
         errors++;
         $display("FAIL ignore_result: %0d edges Q=%h, expected 16 000e0002", n + 5, Q);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      issue(16'd100, 16'd7);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (Q !== '0 || QVALID !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: Q=%h qv=%b busy=%b, expected 0 0 0", Q, QVALID, busy);
      end
      sb.delete();
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (QVALID) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_no_valid: %0d cycles with QVALID, expected 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int t;
      int n;
      logic prev;
      repeat (3) sb.push_back(model(16'd20, 16'd4));
      A     = 16'd20;
      B     = 16'd4;
      start = 1'b1;
      t     = 0;
      n     = 0;
      prev  = 1'b0;
      while (n < 3 && t < 80) begin
         @(posedge clk);
         #1;
         t++;
         if (QVALID) begin
            checks++;
            if (prev) begin
               errors++;
               $display("FAIL b2b_width: QVALID high two cycles at t=%0d", t);
            end
            n++;
            if (n == 3) start = 1'b0;
            checks++;
            if (t !== 17 * n) begin
               errors++;
               $display("FAIL b2b_period[%0d]: pulse at %0d, expected %0d", n, t, 17 * n);
            end
         end
         prev = QVALID;
      end
      start = 1'b0;
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL b2b_timeout: %0d pulses, expected 3", n);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_zero();
      test_ignore();
      test_reset_abort();
      test_back_to_back();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; Q is 2*WIDTH wide.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new division; sampled on each rising edge.
REQ-005 A  input  WIDTH  dividend, unsigned.
REQ-006 B  input  WIDTH  divisor, unsigned.
REQ-007 Q  output  2*WIDTH  result {quotient[WIDTH-1:0], remainder[WIDTH-1:0]}; quotient in Q[31:16], remainder in Q[15:0], matching the result-select opcodes 0101/0110.
REQ-008 QVALID  output  1  Q holds a completed result for the most recently accepted operands.
REQ-009 busy  output  1  division in progress; new start ignored.
REQ-010 div_by_zero  output  1  last completed division had B==0; valid while QVALID=1.

Function
REQ-011 The block SHALL be a registered FSM with states IDLE, RUN, ZERO, DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; on acceptance, the block SHALL latch A and B, clear QVALID and div_by_zero, and set busy the same edge.
REQ-013 On acceptance with B!=0, the next state SHALL be RUN and the iteration counter SHALL be 0.
REQ-014 In RUN, the block SHALL perform one restoring-division step per edge (shift partial remainder left by one, bring in the next dividend MSB, subtract the divisor if not negative, shift the quotient bit in).
REQ-015 After exactly WIDTH RUN edges (counter WIDTH-1 -> wrap), the block SHALL write Q, set QVALID=1, clear busy, and enter DONE; QVALID is thus first high after the WIDTH-th edge following the accepting edge (16 for default).
REQ-016 On acceptance with B==0, the next state SHALL be ZERO; on the following edge, the block SHALL write Q={all-ones, latched A}, set div_by_zero=1 and QVALID=1, clear busy, and enter DONE (latency 2 edges).
REQ-017 Q SHALL hold its previous value during RUN/ZERO and change only on the completing edge.
REQ-018 In DONE, Q, QVALID and div_by_zero SHALL hold indefinitely until the next accepted start.
REQ-019 start asserted in RUN or ZERO SHALL be ignored and have no effect on the operation in flight.
REQ-020 A start held high across completion SHALL be accepted on the first edge in DONE (back-to-back operation); QVALID is then high for exactly one cycle.
REQ-021 Changes on A/B after acceptance SHALL NOT affect the result.
REQ-022 Arithmetic SHALL be unsigned; the partial remainder SHALL be WIDTH+1 bits wide to hold the subtract borrow.

Reset
REQ-023 When rst=1 on an edge, the block SHALL enter IDLE and set Q=0, QVALID=0, busy=0, div_by_zero=0, counter=0, and operand registers=0, regardless of state.
REQ-024 rst SHALL take priority over start; an operation interrupted by reset SHALL be discarded without producing QVALID.

Structure
REQ-025 The state enumeration, WIDTH default, and the result-select opcodes (DIVQ=4'b0101, DIVR=4'b0110) SHALL be placed in the shared CPU package.
REQ-026 One combinational sub-module, div_step, SHALL implement a single restoring-division step (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit); the FSM, counter and registers SHALL remain in divider.

Verification
REQ-027 A=100, B=7, start pulse -> busy for 16 cycles, then Q=32'h000E_0002, QVALID=1, div_by_zero=0.
REQ-028 A=16'hFFFF, B=1 -> Q=32'hFFFF_0000 after 16 cycles; A=3, B=10 -> Q=32'h0000_0003.
REQ-029 A=5, B=0 -> second edge after acceptance: Q=32'hFFFF_0005, QVALID=1, div_by_zero=1.
REQ-030 Start 100/7; at cycle 5 start again with A=9, B=3 -> ignored; result remains 32'h000E_0002 at cycle 16.
REQ-031 Start 100/7; assert rst at cycle 8 -> next edge IDLE, Q=0, QVALID=0, busy=0; no QVALID pulse follows.
REQ-032 start held high continuously with A=20, B=4 -> QVALID pulses one cycle every 17 cycles with Q=32'h0005_0000.
